// File: rtl/weight_buf_pkg.sv
// Weight buffer shared types: SRAM geometry, fetch FSM states, FIFO beat.
// Used by weight_fetch_ctrl and weight_skid_fifo.
package weight_buf_pkg;
  localparam int WEIGHT_ADDR_W = 11;
  localparam int WEIGHT_DATA_W = 128;
  localparam int WEIGHT_DEPTH  = 2016;
  localparam int WEIGHT_LEN_W  = 12;

  typedef enum logic [1:0] {
    WF_IDLE,
    WF_RUN,
    WF_DRAIN
  } wf_state_e;

  typedef logic [WEIGHT_DATA_W-1:0] weight_word_t;
  typedef logic [WEIGHT_ADDR_W-1:0] weight_addr_t;

  typedef struct packed {
    logic         last;
    weight_word_t data;
  } weight_beat_t;

  function automatic weight_addr_t wrap_inc(input weight_addr_t a);
    return (a == weight_addr_t'(WEIGHT_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction
endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO carrying {last, data}; push and pop may coincide.
// Head reads as zero while empty.
module weight_skid_fifo
  import weight_buf_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  weight_beat_t push_beat,
  input  logic         pop,
  output weight_beat_t head,
  output logic [1:0]   count
);
  weight_beat_t mem_q [2];
  weight_beat_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  always_comb begin
    do_pop   = pop & (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM port-A read streamer with write-hazard hold-off.
// Define WEIGHT_FETCH_PERF_EN to add stall_cnt/hazard_cnt outputs.
module weight_fetch_ctrl
  import weight_buf_pkg::*;
(
  input  logic                    CK,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WEIGHT_ADDR_W-1:0] base_addr,
  input  logic [WEIGHT_LEN_W-1:0]  num_words,
  output logic                    busy,
  output logic                    done,
  input  logic                    wr_we_b,
  input  logic [WEIGHT_ADDR_W-1:0] wr_addr_b,
  output logic                    sram_oea,
  output logic [7:0]              sram_wean,
  output logic [WEIGHT_ADDR_W-1:0] sram_a,
  input  logic [WEIGHT_DATA_W-1:0] sram_doa,
  output logic                    w_valid,
  output logic [WEIGHT_DATA_W-1:0] w_data,
  output logic                    w_last,
  input  logic                    w_ready
`ifdef WEIGHT_FETCH_PERF_EN
  ,
  output logic [15:0]             stall_cnt,
  output logic [15:0]             hazard_cnt
`endif
);
  wf_state_e               state_q, state_d;
  weight_addr_t            cur_q, cur_d;
  logic [WEIGHT_LEN_W-1:0] rem_q, rem_d;
  logic                    infl_q, infl_d;
  logic                    infl_last_q, infl_last_d;
  logic                    done_q, done_d;
  logic [1:0]              fifo_cnt;
  logic [1:0]              credit;
  weight_beat_t            head;
  weight_beat_t            push_beat;
  logic                    pop, hazard, can_issue, issue, drained;

  assign pop    = w_valid & w_ready;
  assign hazard = wr_we_b & (wr_addr_b == cur_q);
  // A word popped this cycle frees its slot for the read issued now.
  assign credit = fifo_cnt + {1'b0, infl_q} - {1'b0, pop};

  assign can_issue = (state_q == WF_RUN) & (rem_q != '0) & (credit < 2'd2);
  assign issue     = can_issue & ~hazard;
  assign drained   = ~infl_q & (fifo_cnt == {1'b0, pop});

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    infl_d      = issue;
    infl_last_d = issue & (rem_q == WEIGHT_LEN_W'(1));
    unique case (state_q)
      WF_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = WF_RUN;
            cur_d   = base_addr;
            rem_d   = num_words;
          end
        end
      end
      WF_RUN: begin
        if (issue) begin
          cur_d = wrap_inc(cur_q);
          rem_d = rem_q - 1'b1;
          if (rem_q == WEIGHT_LEN_W'(1)) state_d = WF_DRAIN;
        end
      end
      WF_DRAIN: begin
        if (drained) begin
          state_d = WF_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = WF_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      state_q     <= WF_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  assign push_beat = '{last: infl_last_q, data: sram_doa};

  weight_skid_fifo u_fifo (
    .clk       (CK),
    .rst       (rst),
    .push      (infl_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign busy      = (state_q != WF_IDLE);
  assign done      = done_q;
  assign sram_oea  = issue;
  assign sram_wean = 8'hff;
  assign sram_a    = cur_q;
  assign w_valid   = (fifo_cnt != 2'd0);
  assign w_data    = head.data;
  assign w_last    = head.last;

`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] hazard_cnt_q, hazard_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    hazard_cnt_d = hazard_cnt_q;
    if ((state_q == WF_IDLE) & start) begin
      stall_cnt_d  = '0;
      hazard_cnt_d = '0;
    end else begin
      if (w_valid & ~w_ready & (stall_cnt_q != 16'hffff))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (can_issue & hazard & (hazard_cnt_q != 16'hffff))
        hazard_cnt_d = hazard_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign hazard_cnt = hazard_cnt_q;
`endif
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: SRAM model, run-level reference model,
// per-cycle compare, directed scenarios then randomized runs.
module tb_weight_fetch_ctrl;
  localparam int DEPTH = 2016;

  logic         CK = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [10:0]  base_addr = '0;
  logic [11:0]  num_words = '0;
  logic         busy, done;
  logic         wr_we_b = 1'b0;
  logic [10:0]  wr_addr_b = '0;
  logic [127:0] wr_data = '0;
  logic         sram_oea;
  logic [7:0]   sram_wean;
  logic [10:0]  sram_a;
  logic [127:0] sram_doa = '0;
  logic         w_valid;
  logic [127:0] w_data;
  logic         w_last;
  logic         w_ready = 1'b1;
`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0]  stall_cnt, hazard_cnt;
`endif

  weight_fetch_ctrl dut (
    .CK        (CK),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .wr_we_b   (wr_we_b),
    .wr_addr_b (wr_addr_b),
    .sram_oea  (sram_oea),
    .sram_wean (sram_wean),
    .sram_a    (sram_a),
    .sram_doa  (sram_doa),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_last    (w_last),
    .w_ready   (w_ready)
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .hazard_cnt(hazard_cnt)
`endif
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad = 0;

  function automatic logic [127:0] fval(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return {h, ~h, h ^ 32'hA5A5A5A5, h + 32'd7};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // SRAM: 1-cycle read on port A, write on port B.
  logic [127:0] smem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) smem[i] = fval(i);
  always @(posedge CK) begin
    if (sram_oea) sram_doa <= smem[sram_a];
    if (wr_we_b) smem[wr_addr_b] = wr_data;
  end

  // Run-level reference model.
  bit   armed = 0, rst_seen = 0, m_busy = 0, m_done = 0, busy_now;
  int   m_base = 0, m_num = 0, m_iss = 0, m_hs = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
  int   oea_cnt = 0, max_out = 0;
  bit   prev_stall = 0;
  logic [127:0] prev_data;
  logic prev_last;
  int   iss_addr[$], iss_cyc[$];
  logic [127:0] hs_data[$];

  always @(negedge CK) begin
    cyc++;
    if (armed) begin
      if (rst_seen) begin
        chk("rst_oea", sram_oea, 0);
        chk("rst_a", sram_a, 0);
        chk("rst_valid", w_valid, 0);
        chk("rst_last", w_last, 0);
        chk("rst_data", w_data, 0);
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("wean", sram_wean, 8'hff);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (sram_oea) begin
        oea_cnt++;
        chk("oea_allowed", m_busy && m_iss < m_num, 1);
        chk("sram_a", sram_a, 128'((m_base + m_iss) % DEPTH));
        chk("oea_hazard", wr_we_b && wr_addr_b == sram_a, 0);
        iss_addr.push_back(int'(sram_a));
        iss_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        chk("stall_valid", w_valid, 1);
        chk("stall_data", w_data, prev_data);
        chk("stall_last", w_last, prev_last);
      end
      if (w_valid) begin
        chk("valid_allowed", m_busy && m_hs < m_num, 1);
        chk("w_data", w_data, smem[(m_base + m_hs) % DEPTH]);
        chk("w_last", w_last, m_hs == m_num - 1);
      end else begin
        chk("last_idle", w_last, 0);
      end
    end
    prev_stall = w_valid && !w_ready;
    prev_data  = w_data;
    prev_last  = w_last;
    m_done     = 0;
    rst_seen   = 0;
    if (rst) begin
      m_busy = 0; m_iss = 0; m_hs = 0;
      prev_stall = 0; rst_seen = 1; armed = 1;
    end else if (armed) begin
      busy_now = m_busy;
      if (w_valid && w_ready && m_busy) begin
        hs_data.push_back(w_data);
        m_hs++;
        last_hs_cyc = cyc;
        if (m_hs == m_num) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (sram_oea) m_iss++;
      if (m_busy && m_iss - m_hs > max_out) max_out = m_iss - m_hs;
      if (start && !busy_now) begin
        if (num_words == 0) m_done = 1;
        else begin
          m_busy = 1; m_base = int'(base_addr); m_num = int'(num_words);
          m_iss = 0; m_hs = 0;
          iss_addr.delete(); iss_cyc.delete(); hs_data.delete();
        end
      end
    end
  end

  // PE ready patterns: 0 always, 1 random, 2 = 1,0,0 repeating.
  int rdy_mode = 0, rdy_ph = 0;
  initial forever begin
    @(posedge CK); #1;
    case (rdy_mode)
      0: w_ready = 1'b1;
      1: w_ready = ($urandom_range(0, 3) != 0);
      default: w_ready = (rdy_ph == 0);
    endcase
    rdy_ph = (rdy_ph == 2) ? 0 : rdy_ph + 1;
  end

  // Random port-B writer near the read pointer; content preserving.
  bit wr_mode = 0;
  initial forever begin
    @(posedge CK); #1;
    if (wr_mode) begin
      int a;
      a = (m_base + m_iss + int'($urandom_range(0, 2))) % DEPTH;
      wr_we_b   = $urandom_range(0, 1) == 1;
      wr_addr_b = 11'(a);
      wr_data   = fval(a);
    end
  end

  int done_mark = 0;
  task automatic start_run(input int b, input int n, input int hold);
    @(posedge CK); #1;
    done_mark = done_cnt;
    start = 1; base_addr = 11'(b); num_words = 12'(n);
    repeat (hold) @(posedge CK);
    #1 start = 0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_cnt != done_mark) return;
      @(posedge CK);
    end
    total++; bad++;
    $display("FAIL %s timeout got=no_done exp=done", nm);
  endtask

  int exp2[4] = '{2014, 2015, 0, 1};
  logic [127:0] new5 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  initial begin
    int o0, d0;
    repeat (3) @(posedge CK);
    #1 rst = 0;

    // 1: basic run
    start_run(0, 4, 1);
    wait_done("t1", 100);
    repeat (2) @(posedge CK);
    chk("t1_n_iss", iss_addr.size(), 4);
    for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
      chk("t1_addr", iss_addr[i], i);
      chk("t1_consec", iss_cyc[i] - iss_cyc[0], i);
    end
    chk("t1_n_hs", hs_data.size(), 4);
    chk("t1_done_lat", done_cyc - last_hs_cyc, 1);

    // 2: address wrap
    start_run(2014, 4, 1);
    wait_done("t2", 100);
    repeat (2) @(posedge CK);
    chk("t2_n_iss", iss_addr.size(), 4);
    for (int i = 0; i < 4 && i < iss_addr.size(); i++)
      chk("t2_addr", iss_addr[i], exp2[i]);
    for (int i = 0; i < 4 && i < hs_data.size(); i++)
      chk("t2_data", hs_data[i], fval(exp2[i]));

    // 3: backpressure 1,0,0
    rdy_mode = 2; max_out = 0;
    start_run(300, 8, 1);
    wait_done("t3", 200);
    repeat (2) @(posedge CK);
    rdy_mode = 0;
    chk("t3_n_hs", hs_data.size(), 8);
    for (int i = 0; i < 8 && i < hs_data.size(); i++)
      chk("t3_data", hs_data[i], fval(300 + i));
    chk("t3_max_out", max_out <= 2, 1);

    // 4: write hazard on address 5
    @(posedge CK); #1;
    done_mark = done_cnt;
    start = 1; base_addr = 11'd4; num_words = 12'd3;
    wr_we_b = 1; wr_addr_b = 11'd5; wr_data = new5;
    @(posedge CK); #1 start = 0;
    repeat (3) @(posedge CK);
    #1 wr_we_b = 0;
    wait_done("t4", 100);
    repeat (2) @(posedge CK);
    chk("t4_n_iss", iss_addr.size(), 3);
    if (iss_addr.size() == 3) begin
      chk("t4_addr5", iss_addr[1], 5);
      chk("t4_gap", iss_cyc[1] - iss_cyc[0], 3);
    end
    if (hs_data.size() == 3) chk("t4_data5", hs_data[1], new5);
    chk("t4_sram5", smem[5], new5);
    smem[5] = fval(5);

    // 5: zero-length start
    o0 = oea_cnt;
    start_run(7, 0, 1);
    wait_done("t5", 10);
    repeat (3) @(posedge CK);
    chk("t5_no_oea", oea_cnt - o0, 0);
    chk("t5_one_done", done_cnt - done_mark, 1);

    // 6: reset mid-run, then clean restart
    start_run(50, 10, 1);
    for (int i = 0; i < 100 && m_hs < 3; i++) @(posedge CK);
    #1 rst = 1;
    @(posedge CK); #1 rst = 0;
    d0 = done_cnt;
    repeat (4) @(posedge CK);
    chk("t6_no_done", done_cnt - d0, 0);
    start_run(100, 2, 1);
    wait_done("t6", 100);
    repeat (2) @(posedge CK);
    chk("t6_n_iss", iss_addr.size(), 2);
    for (int i = 0; i < 2 && i < hs_data.size(); i++)
      chk("t6_data", hs_data[i], fval(100 + i));

    // randomized runs with hazards, backpressure, start held while busy
    rdy_mode = 1; wr_mode = 1;
    for (int r = 0; r < 14; r++) begin
      start_run(int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(2, 40)), 3);
      wait_done("rand", 2000);
      repeat ($urandom_range(1, 3)) @(posedge CK);
    end
    start_run(1000, DEPTH, 1);
    wait_done("full", 20000);
    repeat (2) @(posedge CK);
    chk("full_n_hs", hs_data.size(), DEPTH);
    wr_mode = 0;
    #1 wr_we_b = 0;
    rdy_mode = 0;
    repeat (3) @(posedge CK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
